// File: rtl/dec38_onehot_drv_if.sv
// Select-code handshake and decoded one-hot output bundle for dec38_onehot_drv.
// The master side supplies codes and the scan enable. The slave side drives the select lines.
interface dec38_onehot_drv_if;
    logic [2:0] sel_in;
    logic       sel_valid;
    logic       sel_ready;
    logic       scan_en;
    logic [7:0] onehot_out;
    logic       out_valid;
    logic [2:0] scan_pos;
    logic       busy;

    modport master (
        output sel_in, sel_valid, scan_en,
        input  sel_ready, onehot_out, out_valid, scan_pos, busy
    );

    modport slave (
        input  sel_in, sel_valid, scan_en,
        output sel_ready, onehot_out, out_valid, scan_pos, busy
    );
endinterface

// File: rtl/dec38_onehot_drv.sv
// Registered 3-to-8 one-hot decoder. Each accepted code is held for HOLD cycles.
// While no code is pending and scan_en is high, the block rotates through all eight lines.
module dec38_onehot_drv #(
    parameter int unsigned HOLD     = 4,
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    dec38_onehot_drv_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_onehot;
    logic        r_out_valid;
    logic [2:0]  r_scan_pos;
    logic [7:0]  r_hold_cnt;
    logic [15:0] r_scan_cnt;
    logic        r_busy;

    state_t      w_next_state;
    logic [7:0]  w_next_onehot;
    logic [2:0]  w_next_pos;
    logic [7:0]  w_next_hold;
    logic [15:0] w_next_scan;
    logic        w_sel_ready;
    logic        w_accept;

    always_comb begin
        w_sel_ready   = (r_state != ST_HOLD);
        w_accept      = bus.sel_valid & w_sel_ready;
        w_next_state  = r_state;
        w_next_onehot = r_onehot;
        w_next_pos    = r_scan_pos;
        w_next_hold   = r_hold_cnt;
        w_next_scan   = r_scan_cnt;

        case (r_state)
            ST_HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_next_state  = ST_IDLE;
                    w_next_onehot = '0;
                end else begin
                    w_next_hold = r_hold_cnt - 8'd1;
                end
            end
            default: begin
                // IDLE and SCAN share accept handling; accept outranks scan_en and the scan step
                if (w_accept) begin
                    w_next_state  = ST_HOLD;
                    w_next_onehot = 8'(1) << bus.sel_in;
                    w_next_pos    = '0;
                    w_next_hold   = 8'(HOLD - 1);
                end else if (!bus.scan_en) begin
                    w_next_state  = ST_IDLE;
                    w_next_onehot = '0;
                    w_next_pos    = '0;
                end else if (r_state == ST_IDLE) begin
                    w_next_state  = ST_SCAN;
                    w_next_onehot = 8'h01;
                    w_next_pos    = '0;
                    w_next_scan   = 16'(SCAN_DIV - 1);
                end else if (r_scan_cnt == '0) begin
                    w_next_onehot = {r_onehot[6:0], r_onehot[7]};
                    w_next_pos    = r_scan_pos + 3'd1;
                    w_next_scan   = 16'(SCAN_DIV - 1);
                end else begin
                    w_next_scan = r_scan_cnt - 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_onehot    <= '0;
            r_out_valid <= 1'b0;
            r_scan_pos  <= '0;
            r_hold_cnt  <= '0;
            r_scan_cnt  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_onehot    <= w_next_onehot;
            r_out_valid <= |w_next_onehot;
            r_scan_pos  <= w_next_pos;
            r_hold_cnt  <= w_next_hold;
            r_scan_cnt  <= w_next_scan;
            r_busy      <= (w_next_state != ST_IDLE);
        end
    end

    assign bus.sel_ready  = w_sel_ready;
    assign bus.onehot_out = r_onehot;
    assign bus.out_valid  = r_out_valid;
    assign bus.scan_pos   = r_scan_pos;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_dec38_onehot_drv.sv
// Scoreboard bench for dec38_onehot_drv (HOLD=4, SCAN_DIV=2).
// Each task queues the per-cycle outputs it expects and then pops them against the DUT.
module tb_dec38_onehot_drv;

    logic clk;
    logic rst_n;

    dec38_onehot_drv_if bus ();

    dec38_onehot_drv #(.HOLD(4), .SCAN_DIV(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] oh;
        logic       ov;
        logic [2:0] pos;
        logic       rdy;
        logic       bsy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push(input logic [7:0] oh, input logic [2:0] pos,
                                 input logic rdy, input logic bsy);
        sb.push_back({oh, |oh, pos, rdy, bsy});
    endfunction

    function automatic exp_t obs_now();
        return {bus.onehot_out, bus.out_valid, bus.scan_pos, bus.sel_ready, bus.busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Invariant on every cycle: at most one line set, and out_valid tracks onehot_out.
    always @(negedge clk) begin
        checks++;
        if ($countones(bus.onehot_out) > 1 || bus.out_valid !== (|bus.onehot_out)) begin
            errors++;
            $display("FAIL invariant t=%0t got oh=%h ov=%b exp <=1 bit set and ov=|oh",
                     $time, bus.onehot_out, bus.out_valid);
        end
    end

    task automatic test_reset();
        exp_t e, o;
        rst_n         = 1'b0;
        bus.sel_in    = 3'($urandom_range(7));
        bus.sel_valid = 1'($urandom_range(1));
        bus.scan_en   = 1'($urandom_range(1));
        repeat (4) push(8'h00, 3'd0, 1'b1, 1'b0);
        for (int i = 0; sb.size() > 0; i++) begin
            if (i == 0) #3;
            else step();
            e = sb.pop_front();
            o = obs_now();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset[%0d] got oh=%h ov=%b pos=%0d rdy=%b busy=%b exp oh=%h ov=%b pos=%0d rdy=%b busy=%b",
                         i, o.oh, o.ov, o.pos, o.rdy, o.bsy, e.oh, e.ov, e.pos, e.rdy, e.bsy);
            end
            if (i < 2) begin
                bus.sel_in    = 3'($urandom_range(7));
                bus.sel_valid = 1'($urandom_range(1));
                bus.scan_en   = 1'($urandom_range(1));
            end else if (i == 2) begin
                bus.sel_in    = '0;
                bus.sel_valid = 1'b0;
                bus.scan_en   = 1'b0;
                rst_n         = 1'b1;
            end
        end
    endtask

    task automatic test_decode();
        exp_t e, o;
        bus.sel_in    = 3'd5;
        bus.sel_valid = 1'b1;
        repeat (4) push(8'h20, 3'd0, 1'b0, 1'b1);
        push(8'h00, 3'd0, 1'b1, 1'b0);
        for (int i = 0; sb.size() > 0; i++) begin
            step();
            if (i == 0) bus.sel_valid = 1'b0;
            e = sb.pop_front();
            o = obs_now();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL decode[%0d] got oh=%h ov=%b pos=%0d rdy=%b busy=%b exp oh=%h ov=%b pos=%0d rdy=%b busy=%b",
                         i, o.oh, o.ov, o.pos, o.rdy, o.bsy, e.oh, e.ov, e.pos, e.rdy, e.bsy);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, o;
        logic [7:0] pat;
        bus.sel_in    = 3'd0;
        bus.sel_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            pat = 8'h01 << k;
            repeat (4) push(pat, 3'd0, 1'b0, 1'b1);
            push(8'h00, 3'd0, 1'b1, 1'b0);
        end
        for (int i = 0; sb.size() > 0; i++) begin
            step();
            if (i % 5 == 0) begin
                if (i / 5 < 7) bus.sel_in = 3'(i / 5 + 1);
                else bus.sel_valid = 1'b0;
            end
            e = sb.pop_front();
            o = obs_now();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL sweep[%0d] got oh=%h ov=%b pos=%0d rdy=%b busy=%b exp oh=%h ov=%b pos=%0d rdy=%b busy=%b",
                         i, o.oh, o.ov, o.pos, o.rdy, o.bsy, e.oh, e.ov, e.pos, e.rdy, e.bsy);
            end
        end
    endtask

    task automatic test_scan();
        exp_t e, o;
        logic [7:0] pat;
        bus.scan_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pat = 8'h01 << (i / 2);
            push(pat, 3'(i / 2), 1'b1, 1'b1);
        end
        push(8'h01, 3'd0, 1'b1, 1'b1);
        push(8'h00, 3'd0, 1'b1, 1'b0);
        for (int i = 0; sb.size() > 0; i++) begin
            step();
            if (i == 16) bus.scan_en = 1'b0;
            e = sb.pop_front();
            o = obs_now();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL scan[%0d] got oh=%h ov=%b pos=%0d rdy=%b busy=%b exp oh=%h ov=%b pos=%0d rdy=%b busy=%b",
                         i, o.oh, o.ov, o.pos, o.rdy, o.bsy, e.oh, e.ov, e.pos, e.rdy, e.bsy);
            end
        end
    endtask

    task automatic test_preempt();
        exp_t e, o;
        logic [7:0] pat;
        bus.scan_en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            pat = 8'h01 << (i / 2);
            push(pat, 3'(i / 2), 1'b1, 1'b1);
        end
        repeat (4) push(8'h04, 3'd0, 1'b0, 1'b1);
        push(8'h00, 3'd0, 1'b1, 1'b0);
        push(8'h01, 3'd0, 1'b1, 1'b1);
        push(8'h00, 3'd0, 1'b1, 1'b0);
        for (int i = 0; sb.size() > 0; i++) begin
            step();
            if (i == 12) begin
                bus.sel_in    = 3'd2;
                bus.sel_valid = 1'b1;
            end else if (i == 13) begin
                bus.sel_valid = 1'b0;
            end else if (i == 18) begin
                bus.scan_en = 1'b0;
            end
            e = sb.pop_front();
            o = obs_now();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL preempt[%0d] got oh=%h ov=%b pos=%0d rdy=%b busy=%b exp oh=%h ov=%b pos=%0d rdy=%b busy=%b",
                         i, o.oh, o.ov, o.pos, o.rdy, o.bsy, e.oh, e.ov, e.pos, e.rdy, e.bsy);
            end
        end
    endtask

    task automatic test_accept_wins();
        exp_t e, o;
        bus.scan_en = 1'b1;
        push(8'h01, 3'd0, 1'b1, 1'b1);
        repeat (4) push(8'h80, 3'd0, 1'b0, 1'b1);
        push(8'h00, 3'd0, 1'b1, 1'b0);
        for (int i = 0; sb.size() > 0; i++) begin
            step();
            if (i == 0) begin
                bus.scan_en   = 1'b0;
                bus.sel_in    = 3'd7;
                bus.sel_valid = 1'b1;
            end else if (i == 1) begin
                bus.sel_valid = 1'b0;
            end
            e = sb.pop_front();
            o = obs_now();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL accept_wins[%0d] got oh=%h ov=%b pos=%0d rdy=%b busy=%b exp oh=%h ov=%b pos=%0d rdy=%b busy=%b",
                         i, o.oh, o.ov, o.pos, o.rdy, o.bsy, e.oh, e.ov, e.pos, e.rdy, e.bsy);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e, o;
        bus.sel_in    = 3'd7;
        bus.sel_valid = 1'b1;
        repeat (2) push(8'h80, 3'd0, 1'b0, 1'b1);
        repeat (3) push(8'h00, 3'd0, 1'b1, 1'b0);
        for (int i = 0; sb.size() > 0; i++) begin
            if (i == 2) begin
                #2 rst_n = 1'b0;
                #1;
            end else begin
                step();
            end
            if (i == 0) bus.sel_valid = 1'b0;
            if (i == 3) rst_n = 1'b1;
            e = sb.pop_front();
            o = obs_now();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL async_reset[%0d] got oh=%h ov=%b pos=%0d rdy=%b busy=%b exp oh=%h ov=%b pos=%0d rdy=%b busy=%b",
                         i, o.oh, o.ov, o.pos, o.rdy, o.bsy, e.oh, e.ov, e.pos, e.rdy, e.bsy);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t, expected the run to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_scan();
        test_preempt();
        test_accept_wins();
        test_async_reset();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
